serial_adder_ctrl: RTL and testbench

//  Bit-serial N-bit adder built around one fullAdder cell plus a carry flip-flop.

---
 rtl/serial_adder_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop,
//   processing the operands LSB-first at one bit per clock.
//   Ports:
//     clk, reset              clock; synchronous active-high reset
//     startValid/startReady   operand handshake (inA, inB, carryIn sampled on accept)
//     sum, carryOut           result, qualified by doneValid
//     doneValid/doneReady     result handshake
//     busy                    high while shifting or holding a result
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startValid,
    output logic             startReady,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             carryIn,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut,
    output logic             doneValid,
    input  logic             doneReady,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] regB;
    logic [WIDTH-1:0] sumReg;
    logic             carryReg;
    logic [CNT_W-1:0] cnt;
    logic             faSum;
    logic             faCarry;
    logic             accept;
    logic             lastBit;

    // The single full-adder cell shared across all bit positions.
    always_comb begin
        faSum   = regA[0] ^ regB[0] ^ carryReg;
        faCarry = (regA[0] & regB[0]) | (carryReg & (regA[0] ^ regB[0]));
    end

    assign accept  = startValid && (state == IDLE);
    assign lastBit = (cnt == CNT_W'(WIDTH - 1));
    assign sum     = sumReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regA     <= '0;
            regB     <= '0;
            sumReg   <= '0;
            carryReg <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        regA     <= inA;
                        regB     <= inB;
                        carryReg <= carryIn;
                        cnt      <= '0;
                    end
                end
                SHIFT: begin
                    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at sum[0].
                    sumReg   <= {faSum, sumReg[WIDTH-1:1]};
                    carryReg <= faCarry;
                    regA     <= {1'b0, regA[WIDTH-1:1]};
                    regB     <= {1'b0, regB[WIDTH-1:1]};
                    cnt      <= cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        stateNext  = state;
        startReady = 1'b0;
        busy       = 1'b0;
        doneValid  = 1'b0;
        carryOut   = 1'b0;
        case (state)
            IDLE: begin
                startReady = 1'b1;
                if (startValid) begin
                    stateNext = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (lastBit) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                doneValid = 1'b1;
                carryOut  = carryReg;
                if (doneReady) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Directed and randomized checks of serial_adder_ctrl at WIDTH=8 and WIDTH=13.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WIDTH=8 instance
    logic        sv8, sr8, ci8, co8, dv8, dr8, busy8;
    logic [7:0]  a8, b8, sum8;
    // WIDTH=13 instance
    logic        sv13, sr13, ci13, co13, dv13, dr13, busy13;
    logic [12:0] a13, b13, sum13;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset),
        .startValid(sv8), .startReady(sr8),
        .inA(a8), .inB(b8), .carryIn(ci8),
        .sum(sum8), .carryOut(co8),
        .doneValid(dv8), .doneReady(dr8), .busy(busy8)
    );

    serial_adder_ctrl #(.WIDTH(13)) dut13 (
        .clk(clk), .reset(reset),
        .startValid(sv13), .startReady(sr13),
        .inA(a13), .inB(b13), .carryIn(ci13),
        .sum(sum13), .carryOut(co13),
        .doneValid(dv13), .doneReady(dr13), .busy(busy13)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and hold startValid until one edge with startReady high.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic ci, output bit ok);
        int n = 0;
        a8 = a; b8 = b; ci8 = ci; sv8 = 1'b1;
        while (!sr8 && n < 50) begin tick(); n++; end
        ok = sr8;
        tick();
        sv8 = 1'b0;
    endtask

    task automatic start13(input logic [12:0] a, input logic [12:0] b, input logic ci, output bit ok);
        int n = 0;
        a13 = a; b13 = b; ci13 = ci; sv13 = 1'b1;
        while (!sr13 && n < 50) begin tick(); n++; end
        ok = sr13;
        tick();
        sv13 = 1'b0;
    endtask

    // Edge count includes the accept edge itself.
    task automatic waitDone8(output int edges);
        edges = 1;
        while (!dv8 && edges < 60) begin tick(); edges++; end
    endtask

    task automatic waitDone13(output int edges);
        edges = 1;
        while (!dv13 && edges < 60) begin tick(); edges++; end
    endtask

    task automatic finish8();
        dr8 = 1'b1; tick(); dr8 = 1'b0;
    endtask

    task automatic finish13();
        dr13 = 1'b1; tick(); dr13 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({sr8, busy8, dv8, co8, sum8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset8: sr=%b busy=%b dv=%b co=%b sum=%h, want 1 0 0 0 00",
                     sr8, busy8, dv8, co8, sum8);
        end
        checks++;
        if ({sr13, busy13, dv13, co13, sum13} !== {1'b1, 1'b0, 1'b0, 1'b0, 13'h0}) begin
            errors++;
            $display("FAIL reset13: sr=%b busy=%b dv=%b co=%b sum=%h, want 1 0 0 0 0000",
                     sr13, busy13, dv13, co13, sum13);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        bit ok;
        int e;
        start8(8'hFF, 8'h01, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lat_accept: startReady=%b want 1", ok); end
        waitDone8(e);
        checks++;
        if (!dv8 || e != 9) begin
            errors++;
            $display("FAIL latency: dv=%b edges=%0d, want dv=1 edges=9", dv8, e);
        end
        checks++;
        if ({co8, sum8} !== 9'h100) begin
            errors++;
            $display("FAIL ff_plus_01: got co=%b sum=%h, want co=1 sum=00", co8, sum8);
        end
        finish8();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int e;
        start8(8'h7F, 8'h80, 1'b1, ok);
        waitDone8(e);
        checks++;
        if (!dv8 || {co8, sum8} !== 9'h100) begin
            errors++;
            $display("FAIL 7f_80_c1: dv=%b co=%b sum=%h, want dv=1 co=1 sum=00", dv8, co8, sum8);
        end
        finish8();
        start8(8'h35, 8'h1A, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_accept: startReady=%b want 1", ok); end
        waitDone8(e);
        checks++;
        if (!dv8 || e != 9 || {co8, sum8} !== 9'h04F) begin
            errors++;
            $display("FAIL 35_1a: dv=%b edges=%0d co=%b sum=%h, want dv=1 edges=9 co=0 sum=4f",
                     dv8, e, co8, sum8);
        end
        finish8();
    endtask

    task automatic test_backpressure();
        bit ok;
        int e;
        bit stable = 1'b1;
        start8(8'h35, 8'h1A, 1'b0, ok);
        waitDone8(e);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!dv8 || {co8, sum8} !== 9'h04F) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL backpressure: dv=%b co=%b sum=%h, want stable dv=1 co=0 sum=4f",
                     dv8, co8, sum8);
        end
        finish8();
        checks++;
        if ({sr8, busy8, dv8} !== 3'b100) begin
            errors++;
            $display("FAIL release: sr=%b busy=%b dv=%b, want 1 0 0", sr8, busy8, dv8);
        end
    endtask

    task automatic test_ignore_start();
        bit ok;
        int e;
        start8(8'h5A, 8'h3C, 1'b1, ok);
        tick();
        tick();
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; sv8 = 1'b1;
        checks++;
        if (sr8 !== 1'b0) begin
            errors++;
            $display("FAIL shift_ready: startReady=%b want 0", sr8);
        end
        waitDone8(e);
        sv8 = 1'b0;
        checks++;
        if (!dv8 || {co8, sum8} !== 9'h097) begin
            errors++;
            $display("FAIL ignore_start: dv=%b co=%b sum=%h, want dv=1 co=0 sum=97", dv8, co8, sum8);
        end
        finish8();
    endtask

    task automatic test_reset_mid_shift();
        bit ok;
        bit sawDone = 1'b0;
        start8(8'hAA, 8'h55, 1'b0, ok);
        repeat (4) tick();
        checks++;
        if (busy8 !== 1'b1 || dv8 !== 1'b0) begin
            errors++;
            $display("FAIL mid_shift: busy=%b dv=%b, want 1 0", busy8, dv8);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({sr8, busy8, dv8, sum8} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid: sr=%b busy=%b dv=%b sum=%h, want 1 0 0 00", sr8, busy8, dv8, sum8);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dv8) sawDone = 1'b1;
        end
        checks++;
        if (sawDone) begin
            errors++;
            $display("FAIL reset_no_done: doneValid=1 seen, want never");
        end
    endtask

    task automatic test_random8();
        bit ok;
        int e;
        logic [7:0] a, b;
        logic ci;
        logic [8:0] exp;
        for (int t = 0; t < 1000; t++) begin
            a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
            exp = {1'b0, a} + {1'b0, b} + {8'h00, ci};
            start8(a, b, ci, ok);
            waitDone8(e);
            checks++;
            if (!ok || !dv8 || {co8, sum8} !== exp) begin
                errors++;
                $display("FAIL rand8 %h+%h+%b: ok=%b dv=%b got %h want %h", a, b, ci, ok, dv8, {co8, sum8}, exp);
            end
            repeat ($urandom_range(0, 3)) tick();
            checks++;
            if (!dv8 || {co8, sum8} !== exp) begin
                errors++;
                $display("FAIL rand8_stall: dv=%b got %h want %h", dv8, {co8, sum8}, exp);
            end
            finish8();
        end
    endtask

    task automatic test_random13();
        bit ok;
        int e;
        logic [12:0] a, b;
        logic ci;
        logic [13:0] exp;
        for (int t = 0; t < 1000; t++) begin
            a = 13'($urandom); b = 13'($urandom); ci = 1'($urandom);
            exp = {1'b0, a} + {1'b0, b} + {13'h0, ci};
            start13(a, b, ci, ok);
            waitDone13(e);
            checks++;
            if (!ok || !dv13 || e != 14 || {co13, sum13} !== exp) begin
                errors++;
                $display("FAIL rand13 %h+%h+%b: ok=%b dv=%b edges=%0d got %h want %h",
                         a, b, ci, ok, dv13, e, {co13, sum13}, exp);
            end
            repeat ($urandom_range(0, 3)) tick();
            checks++;
            if (!dv13 || {co13, sum13} !== exp) begin
                errors++;
                $display("FAIL rand13_stall: dv=%b got %h want %h", dv13, {co13, sum13}, exp);
            end
            finish13();
        end
    endtask

    initial begin
        reset = 1'b1;
        sv8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; dr8 = 1'b0;
        sv13 = 1'b0; a13 = '0; b13 = '0; ci13 = 1'b0; dr13 = 1'b0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_ignore_start();
        test_reset_mid_shift();
        test_random8();
        test_random13();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
